// File: rtl/mux4_rr_arbiter.sv
// Four-requester round-robin arbiter feeding a one-entry output register.
// The winner's 4-bit data slice and index are captured; the pointer advances past each winner.
module mux4_rr_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  in_val,
    output logic [3:0]  in_rdy,
    input  logic [15:0] in_data,
    output logic        out_val,
    input  logic        out_rdy,
    output logic [3:0]  out_data,
    output logic [1:0]  out_src
);
    // Handshake: a transfer happens on any side where valid and ready are both high
    // in the same cycle; in_rdy never looks at data and is only raised for a valid requester.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] ptr;
    logic [1:0] winner;
    logic       found;
    logic       can_accept;
    logic       in_xfer;
    logic       out_xfer;
    logic [3:0] sel_data;

    // Search order starts at ptr and wraps through the remaining three requesters.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] idx;
            idx = ptr + 2'(k);
            if (!found && in_val[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        sel_data = in_data[3:0];
        case (winner)
            2'd0: sel_data = in_data[3:0];
            2'd1: sel_data = in_data[7:4];
            2'd2: sel_data = in_data[11:8];
            2'd3: sel_data = in_data[15:12];
            default: sel_data = in_data[3:0];
        endcase
    end

    assign can_accept = (state == EMPTY) || out_rdy;
    assign in_rdy     = (can_accept && found && !rst) ? (4'b0001 << winner) : 4'b0000;
    assign in_xfer    = |in_rdy;
    assign out_xfer   = (state == FULL) && out_rdy;
    assign out_val    = (state == FULL);

    always_comb begin
        state_next = state;
        if (in_xfer) begin
            state_next = FULL;
        end else if (out_xfer) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Data, source and pointer only move on an accepted input; they hold through drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= 4'd0;
            out_src  <= 2'd0;
            ptr      <= 2'd0;
        end else if (in_xfer) begin
            out_data <= sel_data;
            out_src  <= winner;
            ptr      <= winner + 2'd1;
        end
    end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: expected {src,data} items queued at acceptance,
// popped and compared by an independent monitor on each output transfer.
module tb_mux4_rr_arbiter;
    logic        clk;
    logic        rst;
    logic [3:0]  in_val;
    logic [3:0]  in_rdy;
    logic [15:0] in_data;
    logic        out_val;
    logic        out_rdy;
    logic [3:0]  out_data;
    logic [1:0]  out_src;

    logic [5:0] exp_q[$];
    int total;
    int bad;

    mux4_rr_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_src  (out_src)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // one clock of stimulus: drive, check in_rdy mid-cycle, queue expected item
    task automatic cyc(input logic [3:0] v, input logic [15:0] d, input logic r,
                       input logic [3:0] er, input logic push, input logic [5:0] item);
        in_val  = v;
        in_data = d;
        out_rdy = r;
        @(negedge clk);
        chk("in_rdy", int'(in_rdy), int'(er));
        if (push) exp_q.push_back(item);
        @(posedge clk);
        #1;
    endtask

    // monitor
    always @(negedge clk) begin
        if (!rst && out_val && out_rdy) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_unexpected: got src=%0d data=0x%0h expected none at %0t",
                         out_src, out_data, $time);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                chk("out_item", int'({out_src, out_data}), int'(e));
            end
        end
    end

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        in_val  = 4'b1111;
        in_data = 16'h4321;
        out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_rdy", int'(in_rdy), 0);
        chk("rst_out_val", int'(out_val), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_src", int'(out_src), 0);
        rst = 1'b0;

        // single request from requester 2, ptr becomes 3
        cyc(4'b0100, 16'h7A5C, 1'b1, 4'b0100, 1'b1, {2'd2, 4'hA});
        chk("lat_out_val", int'(out_val), 1);
        cyc(4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 6'd0);
        chk("drain_out_val", int'(out_val), 0);
        chk("drain_hold_data", int'(out_data), 'hA);
        chk("drain_hold_src", int'(out_src), 2);
        cyc(4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 6'd0);

        // ptr=3: requester 0 wins, ptr=1; then 1001 -> 3, wrap to 0; then 1001 -> 0
        cyc(4'b0001, 16'h9ED3, 1'b1, 4'b0001, 1'b1, {2'd0, 4'h3});
        cyc(4'b1001, 16'h9ED3, 1'b1, 4'b1000, 1'b1, {2'd3, 4'h9});
        cyc(4'b1001, 16'h9ED3, 1'b1, 4'b0001, 1'b1, {2'd0, 4'h3});

        // ptr=1 -> requester 3 moves ptr to 0, then full rotation
        cyc(4'b1000, 16'hB000, 1'b1, 4'b1000, 1'b1, {2'd3, 4'hB});
        cyc(4'b1111, 16'h4321, 1'b1, 4'b0001, 1'b1, {2'd0, 4'h1});
        cyc(4'b1111, 16'h4321, 1'b1, 4'b0010, 1'b1, {2'd1, 4'h2});
        cyc(4'b1111, 16'h4321, 1'b1, 4'b0100, 1'b1, {2'd2, 4'h3});
        cyc(4'b1111, 16'h4321, 1'b1, 4'b1000, 1'b1, {2'd3, 4'h4});
        cyc(4'b1111, 16'h4321, 1'b1, 4'b0001, 1'b1, {2'd0, 4'h1});

        // ptr=1: load 0x5 from requester 1, then 3 stalled cycles
        cyc(4'b1111, 16'h4351, 1'b1, 4'b0010, 1'b1, {2'd1, 4'h5});
        for (int i = 0; i < 3; i++) begin
            cyc(4'b1111, 16'h4321, 1'b0, 4'b0000, 1'b0, 6'd0);
            chk("stall_out_val", int'(out_val), 1);
            chk("stall_out_data", int'(out_data), 'h5);
            chk("stall_out_src", int'(out_src), 1);
        end
        // ptr still 2 after stall
        cyc(4'b1111, 16'h4321, 1'b1, 4'b0100, 1'b1, {2'd2, 4'h3});
        cyc(4'b0000, 16'h4321, 1'b1, 4'b0000, 1'b0, 6'd0);
        chk("idle_out_val", int'(out_val), 0);

        // ptr=3: load requester 1, keep FULL, then async reset mid-cycle
        cyc(4'b0010, 16'h00C0, 1'b0, 4'b0010, 1'b1, {2'd1, 4'hC});
        in_val = 4'b1111;
        #2;
        chk("pre_arst_out_val", int'(out_val), 1);
        rst = 1'b1;
        #1;
        chk("arst_out_val", int'(out_val), 0);
        chk("arst_out_data", int'(out_data), 0);
        chk("arst_out_src", int'(out_src), 0);
        chk("arst_in_rdy", int'(in_rdy), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // post-reset ptr=0
        cyc(4'b1111, 16'h4321, 1'b1, 4'b0001, 1'b1, {2'd0, 4'h1});
        cyc(4'b0000, 16'h4321, 1'b1, 4'b0000, 1'b0, 6'd0);
        cyc(4'b0000, 16'h4321, 1'b1, 4'b0000, 1'b0, 6'd0);
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameters: none; all widths fixed (4 requesters, 4-bit data).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_val  input  4  bit i = requester i has valid data.
REQ-005 in_rdy  output  4  bit i = requester i accepted this cycle; at most one bit set.
REQ-006 in_data  input  16  requester i data at bits [4i+3:4i].
REQ-007 out_val  output  1  output register holds valid data.
REQ-008 out_rdy  input  1  consumer accepts out_data this cycle.
REQ-009 out_data  output  4  registered data of the granted requester.
REQ-010 out_src  output  2  index of the requester that supplied out_data.

Function
REQ-011 State: one-entry output register (EMPTY/FULL), 2-bit priority pointer ptr, out_data, out_src.
REQ-012 Input transfer on requester i: in_val[i] && in_rdy[i] in the same cycle; output transfer: out_val && out_rdy.
REQ-013 Winner: first i with in_val[i]=1, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4); no winner if in_val=0000.
REQ-014 can_accept = (state==EMPTY) || out_rdy.
REQ-015 in_rdy is combinational: one-hot of winner when can_accept && winner exists && !rst; else 0000.
REQ-016 in_rdy never depends on the data value; in_rdy[i]=1 only if in_val[i]=1.
REQ-017 On input transfer: out_data <= in_data slice selected by a 4:1 4-bit mux with sel=winner; out_src <= winner; state <= FULL; ptr <= winner+1 mod 4 (3 wraps to 0).
REQ-018 On output transfer with no simultaneous input transfer: state <= EMPTY; out_data and out_src hold their last values.
REQ-019 Simultaneous output and input transfer in FULL: new data loaded, state stays FULL; sustained throughput is 1 item/cycle.
REQ-020 FULL && !out_rdy: in_rdy=0000; out_data, out_src, ptr, state all hold (stable under backpressure).
REQ-021 ptr changes only on an input transfer; idle cycles and output-only transfers leave ptr unchanged.
REQ-022 out_val = (state==FULL), driven directly from the state register (no combinational input path).
REQ-023 Latency: data accepted in cycle N appears on out_data/out_val in cycle N+1.
REQ-024 Fairness: with all four requesting continuously and out_rdy=1, each requester is granted exactly once per 4 consecutive grants.
REQ-025 Requester dropping in_val before a grant is not latched; there is no request memory.

Reset
REQ-026 rst=1 forces asynchronously, without a clock edge: state=EMPTY, out_val=0, out_data=0000, out_src=00, ptr=00.
REQ-027 While rst=1: in_rdy=0000 regardless of in_val; no transfer occurs.
REQ-028 Reset mid-operation discards held data; first cycle after release behaves as post-reset EMPTY with ptr=0.

Verification
REQ-029 rst=1, in_val=1111 -> in_rdy=0000, out_val=0, out_data=0, out_src=0; async assert between edges drops out_val immediately.
REQ-030 After reset: in_val=0100, in_data[11:8]=0xA, out_rdy=1 -> in_rdy=0100 this cycle; next cycle out_val=1, out_data=0xA, out_src=2; ptr=3.
REQ-031 in_val=1111 continuously, distinct data 0x1/0x2/0x3/0x4 on requesters 0..3, out_rdy=1 -> out_src sequence 0,1,2,3,0 on consecutive cycles, out_data 1,2,3,4,1.
REQ-032 FULL with out_data=0x5, out_rdy=0 for 3 cycles, in_val=1111 -> in_rdy=0000, out_data=0x5, ptr unchanged; cycle out_rdy=1 -> in_rdy one-hot at ptr winner, new data next cycle.
REQ-033 ptr=1, in_val=1001 -> grant requester 3 (in_rdy=1000), ptr wraps to 0; next request set 1001 -> grant requester 0.
REQ-034 FULL, out_rdy=1, in_val=0000 -> next cycle out_val=0, out_data/out_src held, ptr unchanged.
